// File: rtl/lsu_mem_if.sv
// Data-memory handshake bundle between the load/store unit (master) and memory (slave).
interface lsu_mem_if #(
  parameter int DATA_WIDTH = 32
) ();
  logic                  mem_req;
  logic                  mem_we;
  logic [DATA_WIDTH-1:0] mem_addr;
  logic [3:0]            mem_be;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  mem_gnt;
  logic                  mem_rvalid;
  logic [DATA_WIDTH-1:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    input  mem_gnt, mem_rvalid, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    output mem_gnt, mem_rvalid, mem_rdata
  );
endinterface

// File: rtl/lsu.sv
// RV32I load/store unit: store lane alignment, req/gnt/rvalid handshake, load extension.
// Define LSU_MISALIGN_TRAP_EN to turn misaligned H/W accesses into a memoryless misalign pulse.
module lsu #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ex_valid,
  input  logic                  MemRead,
  input  logic                  MemWrite,
  input  logic [2:0]            Funct3,
  input  logic [DATA_WIDTH-1:0] ALUResult,
  input  logic [DATA_WIDTH-1:0] StoreData,
  lsu_mem_if.master             mem,
  output logic [DATA_WIDTH-1:0] ReadData,
  output logic                  lsu_busy,
  output logic                  lsu_done,
  output logic                  lsu_misalign
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    WAIT_R = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic                  req_q, req_d;
  logic                  we_q, we_d;
  logic [DATA_WIDTH-1:0] addr_q, addr_d;
  logic [3:0]            be_q, be_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [2:0]            f3_q, f3_d;
  logic [1:0]            off_q, off_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  mis_q, mis_d;

  logic [1:0]            off_s;
  logic                  misalign_s;

  function automatic logic [3:0] lane_be(input logic [1:0] size, input logic [1:0] off);
    case (size)
      2'b00:   lane_be = 4'b0001 << off;
      2'b01:   lane_be = 4'b0011 << off;
      default: lane_be = 4'b1111;
    endcase
  endfunction

  function automatic logic [DATA_WIDTH-1:0] load_extend(input logic [2:0]            f3,
                                                        input logic [DATA_WIDTH-1:0] word,
                                                        input logic [1:0]            off);
    logic [DATA_WIDTH-1:0] sh;
    sh = word >> {off, 3'b000};
    case (f3)
      3'b000:  load_extend = {{(DATA_WIDTH-8){sh[7]}}, sh[7:0]};
      3'b001:  load_extend = {{(DATA_WIDTH-16){sh[15]}}, sh[15:0]};
      3'b100:  load_extend = {{(DATA_WIDTH-8){1'b0}}, sh[7:0]};
      3'b101:  load_extend = {{(DATA_WIDTH-16){1'b0}}, sh[15:0]};
      default: load_extend = word;
    endcase
  endfunction

  // Effective byte offset and misalignment detection for the incoming request.
  always_comb begin
`ifdef LSU_MISALIGN_TRAP_EN
    off_s      = ALUResult[1:0];
    misalign_s = ((Funct3[1:0] == 2'b01) && ALUResult[0]) ||
                 ((Funct3[1:0] != 2'b00) && (Funct3[1:0] != 2'b01) && (ALUResult[1:0] != 2'b00));
`else
    misalign_s = 1'b0;
    case (Funct3[1:0])
      2'b00:   off_s = ALUResult[1:0];
      2'b01:   off_s = {ALUResult[1], 1'b0};
      default: off_s = 2'b00;
    endcase
`endif
  end

  // Next-state and next-output logic; outputs are registered from the *_d values.
  always_comb begin
    state_d = state_q;
    req_d   = 1'b0;
    we_d    = we_q;
    addr_d  = addr_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    f3_d    = f3_q;
    off_d   = off_q;
    rdata_d = rdata_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    mis_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (ex_valid && (MemRead || MemWrite)) begin
          if (misalign_s) begin
            state_d = DONE;
            done_d  = 1'b1;
            mis_d   = 1'b1;
          end else begin
            state_d = REQ;
            req_d   = 1'b1;
            busy_d  = 1'b1;
            we_d    = MemWrite;
            f3_d    = Funct3;
            off_d   = off_s;
            addr_d  = {ALUResult[DATA_WIDTH-1:2], 2'b00};
            be_d    = lane_be(Funct3[1:0], off_s);
            wdata_d = StoreData << {off_s, 3'b000};
          end
        end else begin
          state_d = IDLE;
        end
      end
      REQ: begin
        if (mem.mem_gnt) begin
          if (we_q) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            state_d = WAIT_R;
            busy_d  = 1'b1;
          end
        end else begin
          req_d  = 1'b1;
          busy_d = 1'b1;
        end
      end
      WAIT_R: begin
        if (mem.mem_rvalid) begin
          state_d = DONE;
          done_d  = 1'b1;
          rdata_d = load_extend(f3_q, mem.mem_rdata, off_q);
        end else begin
          busy_d  = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      be_q    <= 4'b0000;
      wdata_q <= '0;
      f3_q    <= 3'b000;
      off_q   <= 2'b00;
      rdata_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      f3_q    <= f3_d;
      off_q   <= off_d;
      rdata_q <= rdata_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      mis_q   <= mis_d;
    end
  end

  assign mem.mem_req   = req_q;
  assign mem.mem_we    = we_q;
  assign mem.mem_addr  = addr_q;
  assign mem.mem_be    = be_q;
  assign mem.mem_wdata = wdata_q;
  assign ReadData      = rdata_q;
  assign lsu_busy      = busy_q;
  assign lsu_done      = done_q;
  assign lsu_misalign  = mis_q;

endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for lsu: vector table of accesses with a scripted memory slave,
// a scoreboard of completion expectations, plus reset-mid-access and ignored-request sequences.
module tb_lsu;

  logic        clk = 1'b0;
  logic        reset;
  logic        ex_valid;
  logic        MemRead;
  logic        MemWrite;
  logic [2:0]  Funct3;
  logic [31:0] ALUResult;
  logic [31:0] StoreData;
  logic [31:0] ReadData;
  logic        lsu_busy;
  logic        lsu_done;
  logic        lsu_misalign;

  int n_checks = 0;
  int n_fail   = 0;

  lsu_mem_if #(.DATA_WIDTH(32)) mif ();

  lsu #(.DATA_WIDTH(32)) dut (
    .clk          (clk),
    .reset        (reset),
    .ex_valid     (ex_valid),
    .MemRead      (MemRead),
    .MemWrite     (MemWrite),
    .Funct3       (Funct3),
    .ALUResult    (ALUResult),
    .StoreData    (StoreData),
    .mem          (mif),
    .ReadData     (ReadData),
    .lsu_busy     (lsu_busy),
    .lsu_done     (lsu_done),
    .lsu_misalign (lsu_misalign)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] sdata;
    logic [31:0] rdata;
    int          gd;
    int          rd;
    logic        trap;
    logic [31:0] e_addr;
    logic [3:0]  e_be;
    logic [31:0] e_wdata;
    logic [31:0] e_rdata;
  } vec_t;

  typedef struct {
    logic [31:0] rd;
    int          lat;
    logic        mis;
  } exp_t;

  vec_t vecs[14];
  exp_t sb[$];

  function automatic vec_t mk(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                              input logic [31:0] sdata, input logic [31:0] rdata,
                              input int gd, input int rd, input logic trap,
                              input logic [31:0] e_addr, input logic [3:0] e_be,
                              input logic [31:0] e_wdata, input logic [31:0] e_rdata);
    vec_t v;
    v.we = we; v.f3 = f3; v.addr = addr; v.sdata = sdata; v.rdata = rdata;
    v.gd = gd; v.rd = rd; v.trap = trap;
    v.e_addr = e_addr; v.e_be = e_be; v.e_wdata = e_wdata; v.e_rdata = e_rdata;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic check_req(input vec_t v, input string tag);
    chk({tag, "_req"},   {31'd0, mif.mem_req},   32'd1);
    chk({tag, "_busy"},  {31'd0, lsu_busy},      32'd1);
    chk({tag, "_we"},    {31'd0, mif.mem_we},    {31'd0, v.we});
    chk({tag, "_addr"},  mif.mem_addr,           v.e_addr);
    chk({tag, "_be"},    {28'd0, mif.mem_be},    {28'd0, v.e_be});
    chk({tag, "_wdata"}, mif.mem_wdata,          v.e_wdata);
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    exp_t e;
    exp_t got;
    int   edges;
    bit   seen;
    string tag;
    tag = $sformatf("v%0d", idx);
    @(negedge clk);
    ex_valid  = 1'b1;
    MemWrite  = v.we;
    MemRead   = ~v.we;
    Funct3    = v.f3;
    ALUResult = v.addr;
    StoreData = v.sdata;
    e.rd  = v.e_rdata;
    e.lat = v.trap ? 0 : (v.we ? 1 + v.gd : 2 + v.gd + v.rd);
    e.mis = v.trap;
    sb.push_back(e);
    @(posedge clk);
    edges = 0;
    #1;
    ex_valid = 1'b0; MemRead = 1'b0; MemWrite = 1'b0;
    if (!v.trap) begin
      @(negedge clk);
      check_req(v, tag);
      for (int i = 0; i < v.gd; i++) begin
        @(posedge clk); edges++;
        @(negedge clk);
        check_req(v, {tag, "_stall"});
      end
      mif.mem_gnt = 1'b1;
      @(posedge clk); edges++;
      #1 mif.mem_gnt = 1'b0;
      if (!v.we) begin
        for (int i = 0; i < v.rd; i++) begin
          @(negedge clk);
          chk({tag, "_wait_req"},  {31'd0, mif.mem_req}, 32'd0);
          chk({tag, "_wait_busy"}, {31'd0, lsu_busy},    32'd1);
          @(posedge clk); edges++;
        end
        @(negedge clk);
        mif.mem_rvalid = 1'b1;
        mif.mem_rdata  = v.rdata;
        @(posedge clk); edges++;
        #1;
        mif.mem_rvalid = 1'b0;
        mif.mem_rdata  = 32'h0000_0000;
      end
    end
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      if (lsu_done) seen = 1'b1;
      else begin
        @(posedge clk); edges++;
      end
    end
    got = sb.pop_front();
    if (!seen) begin
      chk({tag, "_done_timeout"}, 32'd0, 32'd1);
    end else begin
      chk({tag, "_latency"},  edges,                    got.lat);
      chk({tag, "_readdata"}, ReadData,                 got.rd);
      chk({tag, "_misalign"}, {31'd0, lsu_misalign},    {31'd0, got.mis});
      chk({tag, "_done_busy"}, {31'd0, lsu_busy},       32'd0);
      if (v.trap) chk({tag, "_trap_req"}, {31'd0, mif.mem_req}, 32'd0);
      @(negedge clk);
      chk({tag, "_done_pulse"}, {31'd0, lsu_done}, 32'd0);
      chk({tag, "_idle_busy"},  {31'd0, lsu_busy}, 32'd0);
    end
  endtask

  initial begin
    // we f3 addr sdata rdata gd rd trap | e_addr e_be e_wdata e_rdata
    vecs[0]  = mk(1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 32'h0, 0, 0, 1'b0, 32'h100, 4'b1111, 32'hDEADBEEF, 32'h0);
    vecs[1]  = mk(1'b1, 3'b000, 32'h103, 32'h000000AB, 32'h0, 3, 0, 1'b0, 32'h100, 4'b1000, 32'hAB000000, 32'h0);
    vecs[2]  = mk(1'b1, 3'b001, 32'h102, 32'h0000BEEF, 32'h0, 1, 0, 1'b0, 32'h100, 4'b1100, 32'hBEEF0000, 32'h0);
    vecs[3]  = mk(1'b1, 3'b000, 32'h101, 32'hFFFFFF5A, 32'h0, 0, 0, 1'b0, 32'h100, 4'b0010, 32'hFFFF5A00, 32'h0);
    vecs[4]  = mk(1'b0, 3'b000, 32'h202, 32'h0, 32'h12F45678, 0, 0, 1'b0, 32'h200, 4'b0100, 32'h0, 32'hFFFFFFF4);
    vecs[5]  = mk(1'b0, 3'b100, 32'h202, 32'h0, 32'h12F45678, 1, 1, 1'b0, 32'h200, 4'b0100, 32'h0, 32'h000000F4);
    vecs[6]  = mk(1'b0, 3'b101, 32'h202, 32'h0, 32'h12F45678, 0, 0, 1'b0, 32'h200, 4'b1100, 32'h0, 32'h000012F4);
    vecs[7]  = mk(1'b0, 3'b001, 32'h202, 32'h0, 32'h80010000, 0, 0, 1'b0, 32'h200, 4'b1100, 32'h0, 32'hFFFF8001);
    vecs[8]  = mk(1'b0, 3'b010, 32'h040, 32'h0, 32'hCAFEF00D, 0, 2, 1'b0, 32'h040, 4'b1111, 32'h0, 32'hCAFEF00D);
    vecs[9]  = mk(1'b0, 3'b000, 32'h001, 32'h0, 32'h00007F00, 0, 0, 1'b0, 32'h000, 4'b0010, 32'h0, 32'h0000007F);
    vecs[10] = mk(1'b0, 3'b011, 32'h044, 32'h0, 32'h89ABCDEF, 0, 0, 1'b0, 32'h044, 4'b1111, 32'h0, 32'h89ABCDEF);
`ifdef LSU_MISALIGN_TRAP_EN
    vecs[11] = mk(1'b0, 3'b010, 32'h041, 32'h0, 32'h11223344, 0, 0, 1'b1, 32'h0, 4'b0000, 32'h0, 32'h89ABCDEF);
    vecs[12] = mk(1'b1, 3'b001, 32'h103, 32'h00001234, 32'h0, 0, 0, 1'b1, 32'h0, 4'b0000, 32'h0, 32'h89ABCDEF);
    vecs[13] = mk(1'b0, 3'b101, 32'h201, 32'h0, 32'hAAAA8765, 0, 0, 1'b1, 32'h0, 4'b0000, 32'h0, 32'h89ABCDEF);
`else
    vecs[11] = mk(1'b0, 3'b010, 32'h041, 32'h0, 32'h11223344, 0, 0, 1'b0, 32'h040, 4'b1111, 32'h0, 32'h11223344);
    vecs[12] = mk(1'b1, 3'b001, 32'h103, 32'h00001234, 32'h0, 0, 0, 1'b0, 32'h100, 4'b1100, 32'h12340000, 32'h11223344);
    vecs[13] = mk(1'b0, 3'b101, 32'h201, 32'h0, 32'hAAAA8765, 0, 0, 1'b0, 32'h200, 4'b0011, 32'h0, 32'h00008765);
`endif

    reset = 1'b1; ex_valid = 1'b0; MemRead = 1'b0; MemWrite = 1'b0;
    Funct3 = 3'b000; ALUResult = 32'h0; StoreData = 32'h0;
    mif.mem_gnt = 1'b0; mif.mem_rvalid = 1'b0; mif.mem_rdata = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req",      {31'd0, mif.mem_req},   32'd0);
    chk("rst_we",       {31'd0, mif.mem_we},    32'd0);
    chk("rst_addr",     mif.mem_addr,           32'd0);
    chk("rst_be",       {28'd0, mif.mem_be},    32'd0);
    chk("rst_wdata",    mif.mem_wdata,          32'd0);
    chk("rst_readdata", ReadData,               32'd0);
    chk("rst_busy",     {31'd0, lsu_busy},      32'd0);
    chk("rst_done",     {31'd0, lsu_done},      32'd0);
    chk("rst_misalign", {31'd0, lsu_misalign},  32'd0);
    reset = 1'b0;

    for (int i = 0; i < 14; i++) run_vec(vecs[i], i);

    // ex_valid without a read or write must be ignored
    @(negedge clk);
    ex_valid = 1'b1; Funct3 = 3'b010; ALUResult = 32'h300;
    @(posedge clk);
    #1 ex_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("nop_req",  {31'd0, mif.mem_req}, 32'd0);
      chk("nop_busy", {31'd0, lsu_busy},    32'd0);
      chk("nop_done", {31'd0, lsu_done},    32'd0);
    end

    // reset while a load waits for rvalid
    @(negedge clk);
    ex_valid = 1'b1; MemRead = 1'b1; Funct3 = 3'b010; ALUResult = 32'h80;
    @(posedge clk);
    #1 ex_valid = 1'b0; MemRead = 1'b0;
    @(negedge clk);
    mif.mem_gnt = 1'b1;
    @(posedge clk);
    #1 mif.mem_gnt = 1'b0;
    @(negedge clk);
    chk("rw_wait_busy", {31'd0, lsu_busy},    32'd1);
    chk("rw_wait_req",  {31'd0, mif.mem_req}, 32'd0);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rw_busy",     {31'd0, lsu_busy},    32'd0);
    chk("rw_req",      {31'd0, mif.mem_req}, 32'd0);
    chk("rw_done",     {31'd0, lsu_done},    32'd0);
    chk("rw_readdata", ReadData,             32'd0);
    mif.mem_rvalid = 1'b1; mif.mem_rdata = 32'h5555AAAA;
    @(posedge clk);
    #1 mif.mem_rvalid = 1'b0; mif.mem_rdata = 32'h0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rw_late_done", {31'd0, lsu_done}, 32'd0);
      chk("rw_late_rd",   ReadData,          32'd0);
    end

    run_vec(vecs[0], 100);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
